hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Next-generation hazard unit for the 5-stage RV32I pipeline, replacing the purely combinational one.
//  Keeps the M/W forwarding, load-use stall and branch flush.
//  Adds a per-register pending scoreboard for variable-latency units (MUL/DIV, slow loads) that
//  write back out of band, plus a saturating stall-cycle perf counter.
//  Sits beside the datapath; drives its stall/flush/forward controls.
// PARAMETERS
//  REG_AW   5   register address width; NREGS = 2**REG_AW
//  CNT_W    32  width of stall_cycles perf counter (saturating)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-high
//  Rs1D, Rs2D     in   REG_AW  source regs in Decode
//  RdD            in   REG_AW  dest reg in Decode
//  LongD          in   1       Decode instr targets long-latency unit
//  Rs1E, Rs2E     in   REG_AW  source regs in Execute
//  RdE            in   REG_AW  dest reg in Execute
//  LongE          in   1       Execute instr issues to long unit this cycle
//  ResultSrcE_zero in  1       Execute instr is a load
//  PCSrcE         in   1       taken branch/jump resolved in Execute
//  RdM, RegWriteM in   REG_AW,1  Memory-stage dest / write enable
//  RdW, RegWriteW in   REG_AW,1  Writeback-stage dest / write enable
//  long_ready     in   1       long unit can accept a new op
//  long_wb_valid  in   1       long unit completes and writes long_wb_rd this cycle
//  long_wb_rd     in   REG_AW  completing dest reg
//  StallF, StallD out  1       hold PC / F-D register
//  FlushD, FlushE out  1       clear F-D / D-E register
//  ForwardAE/BE   out  2       00 regfile, 10 from M, 01 from W
//  pending        out  NREGS   scoreboard bits (debug)
//  stall_cycles   out  CNT_W   count of cycles with StallD=1
// BEHAVIOUR
//  Reset (async): pending=0, stall_cycles=0.
//  While reset is high: StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00.
//  Forwarding (comb.): ForwardAE=10 if RegWriteM && RdM==Rs1E && Rs1E!=0;
//   else 01 if RegWriteW && RdW==Rs1E && Rs1E!=0; else 00. M beats W. ForwardBE is the same using Rs2E.
//  lwStall  = ResultSrcE_zero && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  rawStall = pending[Rs1D] || pending[Rs2D]  (pending[0] is always 0).
//  wawStall = LongD && RdD!=0 && pending[RdD].
//  strStall = LongD && !long_ready.
//  stall    = lwStall | rawStall | wawStall | strStall.
//  PCSrcE=1: FlushD=FlushE=1; StallF=StallD=0 (wrong-path D instr discarded).
//  Else: StallF=StallD=stall, FlushE=stall, FlushD=0.
//  Scoreboard update (posedge):
//   - set: pending[RdE] <= 1 when LongE && RdE!=0 && !FlushE.
//   - clear: pending[long_wb_rd] <= 0 when long_wb_valid.
//   - set and clear on the same reg in the same cycle: set wins.
//   - writes to reg 0 are ignored; pending[0] stays 0.
//   - clear of a non-pending reg: no effect.
//  Latency: a reg cleared at edge N unblocks Decode in cycle N+1.
//   Its value comes from the regfile (write-before-read); it is not forwarded from long_wb.
//  stall_cycles: +1 each cycle StallD=1; holds at 2**CNT_W-1. Only reset clears it.
//  Reset mid-operation drops all pending bits. The long unit must be reset too.
// TESTING
//  1. lw x5 in E, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle, then ForwardAE=01.
//  2. RdM=RdW=7, both RegWrite, Rs1E=7 -> ForwardAE=10; RdM=0 case -> 01; Rs1E=0 -> 00.
//  3. LongE, RdE=9; next Rs2D=9 -> stall held until long_wb_valid,rd=9.
//     pending[9] is 0 on the next cycle; stall_cycles equals the stall length.
//  4. LongE RdE=0 -> pending stays 0, no stall. LongD && !long_ready -> stall until ready.
//  5. pending[3]=1, Rs1D=3, PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
//     Same-cycle set+clear of reg 4 -> pending[4]=1.
//  6. Assert reset with pending=0x0000_0204 -> pending=0 immediately, FlushD=FlushE=1.
//     Force the counter to 2**CNT_W-1 and stall once more -> it stays saturated.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage RV32I pipeline: M/W forwarding, load-use stall, branch flush,
// plus a per-register pending scoreboard for out-of-band long-latency writebacks.
module hazard_scoreboard #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [REG_AW-1:0]      Rs1D,
   input  logic [REG_AW-1:0]      Rs2D,
   input  logic [REG_AW-1:0]      RdD,
   input  logic                   LongD,
   input  logic [REG_AW-1:0]      Rs1E,
   input  logic [REG_AW-1:0]      Rs2E,
   input  logic [REG_AW-1:0]      RdE,
   input  logic                   LongE,
   input  logic                   ResultSrcE_zero,
   input  logic                   PCSrcE,
   input  logic [REG_AW-1:0]      RdM,
   input  logic                   RegWriteM,
   input  logic [REG_AW-1:0]      RdW,
   input  logic                   RegWriteW,
   input  logic                   long_ready,
   input  logic                   long_wb_valid,
   input  logic [REG_AW-1:0]      long_wb_rd,
   output logic                   StallF,
   output logic                   StallD,
   output logic                   FlushD,
   output logic                   FlushE,
   output logic [1:0]             ForwardAE,
   output logic [1:0]             ForwardBE,
   output logic [2**REG_AW-1:0]   pending,
   output logic [CNT_W-1:0]       stall_cycles
);

   logic                 lw_stall;
   logic                 raw_stall;
   logic                 waw_stall;
   logic                 str_stall;
   logic                 stall;
   logic                 set_en;
   logic [2**REG_AW-1:0] pending_nxt;

   // M has the younger result, so it wins over W.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                          input logic [REG_AW-1:0] rd_m,
                                          input logic              we_m,
                                          input logic [REG_AW-1:0] rd_w,
                                          input logic              we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (rs != '0) begin
         if (we_m && rd_m == rs)
            sel = 2'b10;
         else if (we_w && rd_w == rs)
            sel = 2'b01;
      end
      return sel;
   endfunction

   assign lw_stall  = ResultSrcE_zero && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign raw_stall = pending[Rs1D] || pending[Rs2D];
   assign waw_stall = LongD && (RdD != '0) && pending[RdD];
   assign str_stall = LongD && !long_ready;
   assign stall     = lw_stall | raw_stall | waw_stall | str_stall;

   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (reset) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else begin
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         if (PCSrcE) begin
            // Wrong-path Decode instruction is discarded, so there is nothing to hold.
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else begin
            StallF = stall;
            StallD = stall;
            FlushE = stall;
         end
      end
   end

   assign set_en = LongE && (RdE != '0) && !FlushE;

   // Clear first, then set, so a same-cycle set on the same register wins.
   always_comb begin
      pending_nxt = pending;
      if (long_wb_valid)
         pending_nxt[long_wb_rd] = 1'b0;
      if (set_en)
         pending_nxt[RdE] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending      <= '0;
         stall_cycles <= '0;
      end else begin
         pending <= pending_nxt;
         if (StallD && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; counter narrowed to 4 bits so saturation is reachable.
module tb_hazard_scoreboard;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 4;

   logic              clk;
   logic              reset;
   logic [REG_AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, long_wb_rd;
   logic              LongD, LongE, ResultSrcE_zero, PCSrcE, RegWriteM, RegWriteW;
   logic              long_ready, long_wb_valid;
   logic              StallF, StallD, FlushD, FlushE;
   logic [1:0]        ForwardAE, ForwardBE;
   logic [31:0]       pending;
   logic [CNT_W-1:0]  stall_cycles;

   int vectors = 0;
   int errors  = 0;

   hazard_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongD(LongD),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LongE(LongE),
      .ResultSrcE_zero(ResultSrcE_zero), .PCSrcE(PCSrcE),
      .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
      .long_ready(long_ready), .long_wb_valid(long_wb_valid), .long_wb_rd(long_wb_rd),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .pending(pending), .stall_cycles(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      Rs1D = '0; Rs2D = '0; RdD = '0; LongD = 1'b0;
      Rs1E = '0; Rs2E = '0; RdE = '0; LongE = 1'b0;
      ResultSrcE_zero = 1'b0; PCSrcE = 1'b0;
      RdM = '0; RegWriteM = 1'b0; RdW = '0; RegWriteW = 1'b0;
      long_ready = 1'b1; long_wb_valid = 1'b0; long_wb_rd = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      step();
      check("rst_pending", pending, 32'h0);
      check("rst_count", 32'(stall_cycles), 32'd0);
      check("rst_flush", {30'd0, FlushD, FlushE}, 32'h3);
      check("rst_stall", {30'd0, StallF, StallD}, 32'h0);
      reset = 1'b0;
      step();

      // Load-use: lw x5 in E, consumer of x5 in D.
      ResultSrcE_zero = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
      #1;
      check("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'h7);
      check("lw_flushd", 32'(FlushD), 32'd0);
      step();
      idle(); Rs1D = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
      #1;
      check("lw_released", 32'(StallD), 32'd0);
      step();
      idle(); Rs1E = 5'd5; RdW = 5'd5; RegWriteW = 1'b1;
      #1;
      check("lw_fwd_w", 32'(ForwardAE), 32'd1);
      check("lw_count", 32'(stall_cycles), 32'd1);
      step();

      // Forwarding priority and x0.
      idle(); RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7; Rs2E = 5'd7;
      #1;
      check("fwd_m_wins", 32'(ForwardAE), 32'd2);
      check("fwd_b_m", 32'(ForwardBE), 32'd2);
      RdM = 5'd0;
      #1;
      check("fwd_w_only", 32'(ForwardAE), 32'd1);
      Rs1E = 5'd0; RdM = 5'd0; RdW = 5'd0;
      #1;
      check("fwd_x0", 32'(ForwardAE), 32'd0);
      RegWriteM = 1'b0; RdM = 5'd7; RdW = 5'd3;
      #1;
      check("fwd_no_we", 32'(ForwardBE), 32'd0);
      step();

      // Long op to x9, then consumer stalls until writeback.
      idle(); LongE = 1'b1; RdE = 5'd9;
      #1;
      check("long_issue_nostall", 32'(StallD), 32'd0);
      step();
      idle(); Rs2D = 5'd9;
      for (int i = 0; i < 3; i++) begin
         long_wb_valid = (i == 2); long_wb_rd = 5'd9;
         #1;
         check("raw_pending", pending, 32'h0000_0200);
         check("raw_stall", {30'd0, StallF, StallD}, 32'h3);
         step();
      end
      idle(); Rs2D = 5'd9;
      #1;
      check("raw_cleared", pending, 32'h0);
      check("raw_released", 32'(StallD), 32'd0);
      check("raw_count", 32'(stall_cycles), 32'd4);
      step();

      // Long op to x0 is ignored; structural stall on busy unit.
      idle(); LongE = 1'b1; RdE = 5'd0;
      step();
      idle();
      #1;
      check("long_x0_pending", pending, 32'h0);
      check("long_x0_nostall", 32'(StallD), 32'd0);
      LongD = 1'b1; RdD = 5'd12; long_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("str_stall", 32'(StallD), 32'd1);
         step();
      end
      long_ready = 1'b1;
      #1;
      check("str_released", 32'(StallD), 32'd0);
      check("str_count", 32'(stall_cycles), 32'd6);
      step();

      // Branch flush overrides scoreboard stall.
      idle(); LongE = 1'b1; RdE = 5'd3;
      step();
      idle(); Rs1D = 5'd3; PCSrcE = 1'b1;
      #1;
      check("br_flush", {30'd0, FlushD, FlushE}, 32'h3);
      check("br_nostall", {30'd0, StallF, StallD}, 32'h0);
      step();
      check("br_count", 32'(stall_cycles), 32'd6);
      // WAW: long op in D targets pending x3; a long op in E is flushed and must not set.
      idle(); LongD = 1'b1; RdD = 5'd3; LongE = 1'b1; RdE = 5'd6;
      #1;
      check("waw_stall", {30'd0, StallD, FlushE}, 32'h3);
      step();
      check("flushed_no_set", pending, 32'h0000_0008);
      // Same-cycle set and clear of x4 -> set wins; clear of idle x10 has no effect.
      idle(); LongE = 1'b1; RdE = 5'd4; long_wb_valid = 1'b1; long_wb_rd = 5'd4;
      step();
      idle(); long_wb_valid = 1'b1; long_wb_rd = 5'd10;
      step();
      check("set_wins", pending, 32'h0000_0018);
      check("waw_count", 32'(stall_cycles), 32'd7);

      // Build pending = 0x204, then assert reset mid-operation.
      idle(); long_wb_valid = 1'b1; long_wb_rd = 5'd3;
      step();
      idle(); long_wb_valid = 1'b1; long_wb_rd = 5'd4; LongE = 1'b1; RdE = 5'd2;
      step();
      idle(); LongE = 1'b1; RdE = 5'd9;
      step();
      idle();
      #1;
      check("pre_reset_pending", pending, 32'h0000_0204);
      Rs1D = 5'd9; ResultSrcE_zero = 1'b1; RdE = 5'd9; Rs1E = 5'd7; RdM = 5'd7; RegWriteM = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_pending", pending, 32'h0);
      check("async_rst_flush", {30'd0, FlushD, FlushE}, 32'h3);
      check("async_rst_stall", {30'd0, StallF, StallD}, 32'h0);
      check("async_rst_fwd", 32'(ForwardAE), 32'd0);
      check("async_rst_count", 32'(stall_cycles), 32'd0);
      step();
      reset = 1'b0;
      idle();
      step();

      // Drive the counter to its ceiling, then stall once more.
      LongD = 1'b1; long_ready = 1'b0;
      for (int i = 0; i < 15; i++) step();
      check("cnt_max", 32'(stall_cycles), 32'd15);
      step();
      check("cnt_saturated", 32'(stall_cycles), 32'd15);
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
